mem_port_arbiter: RTL and testbench

- Two-requester arbiter for the single shared memory port of the CPU datapath.
- Requester 0 is instruction fetch; requester 1 is data load/store.
- Drives the select input of the existing 2:1 address/write-data muxes (sel=0 picks requester 0 on mux input a, sel=1 picks requester 1 on input b).
- Sequences one memory transaction at a time, returns the acknowledge to the owner, and aborts hung transactions with a watchdog.

---
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared CPU memory port.
// Requester 0 is instruction fetch; requester 1 is data load/store.
// Runs one memory transaction at a time, returns ack to the owner,
// and aborts a hung transaction after TIMEOUT busy cycles.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   req0     in   requester 0 request, held until ack0/err0
//   req1     in   requester 1 request, held until ack1/err1
//   mem_ack  in   memory completion strobe, valid while mem_req=1
//   mem_req  out  request to the memory port
//   sel      out  address/write-data mux select (1 = requester 1)
//   gnt0     out  requester 0 owns the port
//   gnt1     out  requester 1 owns the port
//   ack0     out  completion pulse to requester 0
//   ack1     out  completion pulse to requester 1
//   err0     out  timeout-abort pulse to requester 0
//   err1     out  timeout-abort pulse to requester 1
//   busy     out  a transaction is in progress
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic mem_ack,
    output logic mem_req,
    output logic sel,
    output logic gnt0,
    output logic gnt1,
    output logic ack0,
    output logic ack1,
    output logic err0,
    output logic err1,
    output logic busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    // Counter value seen in the last permitted busy cycle.
    localparam logic [CW-1:0] TMO_CNT = CW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_n;
    logic          last;
    logic          last_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          tmo;

    assign tmo = (cnt == TMO_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                // On a tie, the requester not served last wins.
                if (req0 && (!req1 || last)) begin
                    state_n = BUSY0;
                end else if (req1) begin
                    state_n = BUSY1;
                end
            end
            BUSY0: begin
                if (mem_ack || tmo) begin
                    state_n = IDLE;
                    last_n  = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BUSY1: begin
                if (mem_ack || tmo) begin
                    state_n = IDLE;
                    last_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        gnt0    = (state == BUSY0);
        gnt1    = (state == BUSY1);
        mem_req = gnt0 | gnt1;
        busy    = gnt0 | gnt1;
        sel     = gnt1;
        ack0    = gnt0 & mem_ack;
        ack1    = gnt1 & mem_ack;
        // An ack in the timeout cycle wins over the abort.
        err0    = gnt0 & ~mem_ack & tmo;
        err1    = gnt1 & ~mem_ack & tmo;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with TIMEOUT=4.
// Each step drives inputs just after a rising edge and checks outputs mid-cycle.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;
    logic req0;
    logic req1;
    logic mem_ack;
    logic mem_req;
    logic sel;
    logic gnt0;
    logic gnt1;
    logic ack0;
    logic ack1;
    logic err0;
    logic err1;
    logic busy;

    int passed = 0;
    int total  = 0;

    mem_port_arbiter #(
        .TIMEOUT (4),
        .CW      (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .mem_ack (mem_ack),
        .mem_req (mem_req),
        .sel     (sel),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .ack0    (ack0),
        .ack1    (ack1),
        .err0    (err0),
        .err1    (err1),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output vector {mem_req,sel,gnt0,gnt1,ack0,ack1,err0,err1,busy}.
    function automatic logic [8:0] v(input logic g0, input logic g1,
                                     input logic a0, input logic a1,
                                     input logic e0, input logic e1);
        return {g0 | g1, g1, g0, g1, a0, a1, e0, e1, g0 | g1};
    endfunction

    localparam logic [8:0] Z = 9'b0;

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {mem_req, sel, gnt0, gnt1, ack0, ack1, err0, err1, busy};
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r0, input logic r1, input logic a);
        @(posedge clk);
        #1;
        req0    = r0;
        req1    = r1;
        mem_ack = a;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        req0    = 1'b0;
        req1    = 1'b0;
        mem_ack = 1'b0;
        #3;
        chk("reset_outputs", Z);
        #9;
        rst = 1'b0;

        cyc(0, 0, 0); chk("idle_a", Z);
        cyc(0, 0, 0); chk("idle_b", Z);

        // Tie after reset: requester 0 first (last=1).
        cyc(1, 1, 0); chk("tie_c1", Z);
        cyc(1, 1, 0); chk("tie_c2", v(1, 0, 0, 0, 0, 0));
        cyc(1, 1, 1); chk("tie_c3", v(1, 0, 1, 0, 0, 0));
        cyc(0, 1, 0); chk("tie_c4", Z);
        cyc(0, 1, 0); chk("tie_c5", v(0, 1, 0, 0, 0, 0));
        cyc(0, 1, 1); chk("tie_c6", v(0, 1, 0, 1, 0, 0));
        cyc(0, 0, 0); chk("tie_c7", Z);

        // Single requester 0, ack in cycle 4.
        cyc(1, 0, 0); chk("single_c1", Z);
        cyc(1, 0, 0); chk("single_c2", v(1, 0, 0, 0, 0, 0));
        cyc(1, 0, 0); chk("single_c3", v(1, 0, 0, 0, 0, 0));
        cyc(1, 0, 1); chk("single_c4", v(1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0); chk("single_c5", Z);

        // Stray ack while idle.
        cyc(0, 0, 1); chk("idle_ack_a", Z);
        cyc(0, 0, 0); chk("idle_ack_b", Z);

        // Reset in BUSY1 with cnt=2; last was 0, reset restores 1.
        cyc(0, 1, 0); chk("rmid_c1", Z);
        cyc(0, 1, 0); chk("rmid_c2", v(0, 1, 0, 0, 0, 0));
        cyc(0, 1, 0); chk("rmid_c3", v(0, 1, 0, 0, 0, 0));
        cyc(0, 1, 0); chk("rmid_c4", v(0, 1, 0, 0, 0, 0));
        #1;
        rst = 1'b1;
        #1;
        chk("rmid_async", Z);
        req0 = 1'b1;
        req1 = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rmid_held", Z);
        cyc(1, 1, 0); chk("rmid_gnt0", v(1, 0, 0, 0, 0, 0));
        cyc(1, 1, 1); chk("rmid_ack0", v(1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0); chk("rmid_idle", Z);

        // Round-robin with both requesting; last=0 so requester 1 first.
        cyc(1, 1, 0); chk("rr_idle0", Z);
        cyc(1, 1, 1); chk("rr_g1a", v(0, 1, 0, 1, 0, 0));
        cyc(1, 1, 0); chk("rr_idle1", Z);
        cyc(1, 1, 1); chk("rr_g0a", v(1, 0, 1, 0, 0, 0));
        cyc(1, 1, 0); chk("rr_idle2", Z);
        cyc(1, 1, 1); chk("rr_g1b", v(0, 1, 0, 1, 0, 0));
        cyc(1, 1, 0); chk("rr_idle3", Z);
        cyc(1, 1, 1); chk("rr_g0b", v(1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0); chk("rr_end", Z);

        // Timeout: err1 in the 4th busy cycle.
        cyc(0, 1, 0); chk("tmo_c1", Z);
        cyc(0, 1, 0); chk("tmo_b1", v(0, 1, 0, 0, 0, 0));
        cyc(0, 1, 0); chk("tmo_b2", v(0, 1, 0, 0, 0, 0));
        cyc(0, 1, 0); chk("tmo_b3", v(0, 1, 0, 0, 0, 0));
        cyc(0, 1, 0); chk("tmo_b4", v(0, 1, 0, 0, 0, 1));
        cyc(0, 0, 0); chk("tmo_end", Z);

        // Ack in the timeout cycle wins.
        cyc(0, 1, 0); chk("tack_c1", Z);
        cyc(0, 1, 0); chk("tack_b1", v(0, 1, 0, 0, 0, 0));
        cyc(0, 1, 0); chk("tack_b2", v(0, 1, 0, 0, 0, 0));
        cyc(0, 1, 0); chk("tack_b3", v(0, 1, 0, 0, 0, 0));
        cyc(0, 1, 1); chk("tack_b4", v(0, 1, 0, 1, 0, 0));
        cyc(0, 0, 0); chk("tack_end", Z);

        // Non-owner held off, then wins round-robin.
        cyc(1, 0, 0); chk("hold_c1", Z);
        cyc(1, 1, 0); chk("hold_c2", v(1, 0, 0, 0, 0, 0));
        cyc(1, 1, 1); chk("hold_c3", v(1, 0, 1, 0, 0, 0));
        cyc(1, 1, 0); chk("hold_c4", Z);
        cyc(1, 1, 1); chk("hold_c5", v(0, 1, 0, 1, 0, 0));
        cyc(0, 0, 0); chk("hold_c6", Z);

        // Owner drops req during busy: grant kept until ack.
        cyc(1, 0, 0); chk("drop_c1", Z);
        cyc(1, 0, 0); chk("drop_c2", v(1, 0, 0, 0, 0, 0));
        cyc(0, 0, 0); chk("drop_c3", v(1, 0, 0, 0, 0, 0));
        cyc(0, 0, 1); chk("drop_c4", v(1, 0, 1, 0, 0, 0));
        cyc(0, 0, 0); chk("drop_c5", Z);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
